ram_arbiter: RTL and testbench

//  Downstream of the DMA engine's RAM port. Accepts toggle-handshake byte requests from two

---
 rtl/ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-master arbiter in front of an external asynchronous 8-bit SRAM.
// Port A (DMA engine) and port B (host/register bridge) each issue single
// byte reads or writes over a toggle handshake. Accesses are serialised
// onto the SRAM with a fixed number of wait states. When both ports are
// waiting, the port that was not served last wins.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   a_addr/a_d/a_we       port A address, write data, 1=write 0=read
//   a_req/a_ack           port A request/acknowledge toggles
//   a_q                   port A read data (held until the next A read)
//   b_*                   same set for port B
//   sram_a/sram_do        SRAM address and write data (registered)
//   sram_di               SRAM read data
//   sram_doe              drive sram_do onto the SRAM data bus
//   sram_ce_n/oe_n/we_n   SRAM strobes, active low (registered)
//   state_dbg             current FSM state (IDLE=0, ACCESS=1, RECOVER=2)
//
// Handshake: a port has a request pending while its req differs from its
// ack. Address, data and we are sampled on the grant edge, so the master may
// change them once the access has started. The arbiter completes a request
// by toggling ack so that it equals req again; for reads, q is valid from
// that same edge.
module ram_arbiter #(
    parameter int ram_a_bits  = 17,
    parameter int wait_cycles = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ram_a_bits-1:0] a_addr,
    input  logic [7:0]            a_d,
    input  logic                  a_we,
    input  logic                  a_req,
    output logic                  a_ack,
    output logic [7:0]            a_q,
    input  logic [ram_a_bits-1:0] b_addr,
    input  logic [7:0]            b_d,
    input  logic                  b_we,
    input  logic                  b_req,
    output logic                  b_ack,
    output logic [7:0]            b_q,
    output logic [ram_a_bits-1:0] sram_a,
    output logic [7:0]            sram_do,
    input  logic [7:0]            sram_di,
    output logic                  sram_doe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    // cnt only ever holds wait_cycles-1 down to 0
    localparam int CW = $clog2(wait_cycles);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_b;  // 1 when the most recent grant went to port B
    logic          cur_b;   // port currently in service
    logic          cur_we;  // operation currently in service
    logic          a_pend;
    logic          b_pend;
    logic          pick_b;

    assign a_pend    = a_req != a_ack;
    assign b_pend    = b_req != b_ack;
    assign state_dbg = state;

    // With both ports waiting the grant alternates away from the last winner,
    // so neither master can be held off for more than one access.
    always_comb begin
        pick_b = 1'b0;
        if (a_pend && b_pend) pick_b = ~last_b;
        else                  pick_b = b_pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Any pending request is dropped, not completed.
            a_ack     <= a_req;
            b_ack     <= b_req;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            sram_a    <= '0;
            sram_do   <= 8'h00;
            sram_doe  <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            state     <= IDLE;
            last_b    <= 1'b1;
            cur_b     <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_pend || b_pend) begin
                        cur_b     <= pick_b;
                        last_b    <= pick_b;
                        cur_we    <= pick_b ? b_we : a_we;
                        sram_a    <= pick_b ? b_addr : a_addr;
                        sram_ce_n <= 1'b0;
                        if (pick_b ? b_we : a_we) begin
                            sram_do   <= pick_b ? b_d : a_d;
                            sram_doe  <= 1'b1;
                            sram_we_n <= 1'b0;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                        cnt   <= CW'(wait_cycles - 1);
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt == '0) begin
                        if (!cur_we) begin
                            if (cur_b) b_q <= sram_di;
                            else       a_q <= sram_di;
                        end
                        if (cur_b) b_ack <= ~b_ack;
                        else       a_ack <= ~a_ack;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_doe  <= 1'b0;
                        state     <= RECOVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                        // we_n rises one cycle before ce_n so the write data
                        // is still driven for a full hold cycle afterwards.
                        if (cnt == CW'(1)) sram_we_n <= 1'b1;
                    end
                end

                RECOVER: begin
                    // Bus turnaround; address and data registers hold.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: fixed vectors, hand-written timing sequences
// and randomized two-port traffic checked against a transaction-level model.
module tb_ram_arbiter;

    localparam int W  = 2;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc  = 0;
    int viol = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT with wait_cycles=2 ----------------
    logic [16:0] a_addr, b_addr, sram_a;
    logic [7:0]  a_d, b_d, a_q, b_q, sram_do, sram_di;
    logic        a_we, b_we, a_req, b_req, a_ack, b_ack;
    logic        sram_doe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  state_dbg;

    ram_arbiter #(.ram_a_bits(17), .wait_cycles(W)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_d(a_d), .a_we(a_we), .a_req(a_req), .a_ack(a_ack), .a_q(a_q),
        .b_addr(b_addr), .b_d(b_d), .b_we(b_we), .b_req(b_req), .b_ack(b_ack), .b_q(b_q),
        .sram_a(sram_a), .sram_do(sram_do), .sram_di(sram_di), .sram_doe(sram_doe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .state_dbg(state_dbg)
    );

    // Asynchronous SRAM model: reads combinational, writes sampled while we_n low.
    logic [7:0] mem [0:131071];
    assign sram_di = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'hEE;
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_a] <= sram_do;

    // ---------------- DUT with wait_cycles=4 ----------------
    logic [16:0] a4_addr, b4_addr, sram4_a;
    logic [7:0]  a4_d, b4_d, a4_q, b4_q, sram4_do, sram4_di;
    logic        a4_we, b4_we, a4_req, b4_req, a4_ack, b4_ack;
    logic        sram4_doe, sram4_ce_n, sram4_oe_n, sram4_we_n;
    logic [1:0]  state4_dbg;

    ram_arbiter #(.ram_a_bits(17), .wait_cycles(W4)) dut4 (
        .clk(clk), .reset(reset),
        .a_addr(a4_addr), .a_d(a4_d), .a_we(a4_we), .a_req(a4_req), .a_ack(a4_ack), .a_q(a4_q),
        .b_addr(b4_addr), .b_d(b4_d), .b_we(b4_we), .b_req(b4_req), .b_ack(b4_ack), .b_q(b4_q),
        .sram_a(sram4_a), .sram_do(sram4_do), .sram_di(sram4_di), .sram_doe(sram4_doe),
        .sram_ce_n(sram4_ce_n), .sram_oe_n(sram4_oe_n), .sram_we_n(sram4_we_n),
        .state_dbg(state4_dbg)
    );

    // Fixed-content ROM-like model: 0xC3 at 0x00100, low address byte ^ 0x5A elsewhere.
    assign sram4_di = (!sram4_ce_n && !sram4_oe_n) ?
                      ((sram4_a == 17'h00100) ? 8'hC3 : (sram4_a[7:0] ^ 8'h5A)) : 8'hEE;

    // SRAM bus sanity on both instances.
    always @(negedge clk) begin
        if (!sram_we_n && (!sram_doe || sram_ce_n)) viol <= viol + 1;
        if (!sram_oe_n && (sram_doe || sram_ce_n))  viol <= viol + 1;
        if (!sram4_we_n && (!sram4_doe || sram4_ce_n)) viol <= viol + 1;
        if (!sram4_oe_n && (sram4_doe || sram4_ce_n))  viol <= viol + 1;
    end

    // ---------------- scoreboard helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pending(input int p);
        return (p == 0) ? (a_req != a_ack) : (b_req != b_ack);
    endfunction

    task automatic issue(input int p, input logic we, input logic [16:0] addr, input logic [7:0] d);
        if (p == 0) begin
            a_we = we; a_addr = addr; a_d = d; a_req = ~a_req;
        end else begin
            b_we = we; b_addr = addr; b_d = d; b_req = ~b_req;
        end
    endtask

    // One access on an idle arbiter; returns latency in clocks, strobe-low
    // counts, the address seen on the grant cycle and the read data.
    task automatic run_single(input int p, input logic we, input logic [16:0] addr,
                              input logic [7:0] d, output int lat, output int we_lo,
                              output int oe_lo, output logic [16:0] gaddr, output logic [7:0] q);
        logic seen;
        seen = 1'b0; lat = 0; we_lo = 0; oe_lo = 0; gaddr = '0;
        issue(p, we, addr, d);
        while (pending(p) && lat < 50) begin
            tick();
            lat++;
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (!sram_ce_n && !seen) begin
                gaddr = sram_a;
                seen  = 1'b1;
            end
        end
        check("ack_timeout", int'(pending(p)), 0);
        q = (p == 0) ? a_q : b_q;
        tick();
        tick();
    endtask

    task automatic run4(input int p, input logic we, input logic [16:0] addr,
                        input logic [7:0] d, output int lat, output int oe_lo);
        lat = 0; oe_lo = 0;
        if (p == 0) begin a4_we = we; a4_addr = addr; a4_d = d; a4_req = ~a4_req; end
        else        begin b4_we = we; b4_addr = addr; b4_d = d; b4_req = ~b4_req; end
        while (((p == 0) ? (a4_req != a4_ack) : (b4_req != b4_ack)) && lat < 50) begin
            tick();
            lat++;
            if (!sram4_oe_n) oe_lo++;
        end
        check("ack4_timeout", int'((p == 0) ? (a4_req != a4_ack) : (b4_req != b4_ack)), 0);
        tick();
        tick();
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  d;
        logic [7:0]  exp_q;
    } vec_t;

    vec_t vecs[8];

    // randomized-phase model state
    logic [16:0] pool [8];
    logic [7:0]  ref_mem [logic [16:0]];
    logic        out_v  [2];
    logic        out_we [2];
    logic [16:0] out_addr [2];
    logic [7:0]  out_d  [2];
    int          out_k  [2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, we_lo, oe_lo, k, t_a, t_b, t_bg, ce_hi, doe_cnt, n, b_iss, b_lat, a_cnt;
        logic [16:0] ga, g1addr;
        logic [7:0] q;
        logic gap_done, a_out, b_out;
        int ord[$];
        int t[3];
        logic [16:0] rd_addr [3];
        logic [7:0]  rd_exp  [3];

        vecs[0] = '{0, 1'b1, 17'h00000, 8'h01, 8'h00};
        vecs[1] = '{1, 1'b1, 17'h1FFFF, 8'hFE, 8'h00};
        vecs[2] = '{0, 1'b0, 17'h1FFFF, 8'h00, 8'hFE};
        vecs[3] = '{1, 1'b0, 17'h00000, 8'h00, 8'h01};
        vecs[4] = '{0, 1'b1, 17'h0AAAA, 8'hA5, 8'h00};
        vecs[5] = '{1, 1'b1, 17'h15555, 8'h3C, 8'h00};
        vecs[6] = '{1, 1'b0, 17'h0AAAA, 8'h00, 8'hA5};
        vecs[7] = '{0, 1'b0, 17'h15555, 8'h00, 8'h3C};

        a_addr = '0; a_d = '0; a_we = 1'b0; a_req = 1'b1;
        b_addr = '0; b_d = '0; b_we = 1'b0; b_req = 1'b0;
        a4_addr = '0; a4_d = '0; a4_we = 1'b0; a4_req = 1'b0;
        b4_addr = '0; b4_d = '0; b4_we = 1'b0; b4_req = 1'b0;

        // ---- reset state ----
        reset = 1'b1;
        tick();
        tick();
        check("rst_a_ack", int'(a_ack), 1);
        check("rst_b_ack", int'(b_ack), 0);
        check("rst_a_q", int'(a_q), 0);
        check("rst_b_q", int'(b_q), 0);
        check("rst_sram_a", int'(sram_a), 0);
        check("rst_sram_do", int'(sram_do), 0);
        check("rst_strobes", int'({sram_doe, sram_ce_n, sram_oe_n, sram_we_n}), 'b0111);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();

        // ---- write then read on port A ----
        run_single(0, 1'b1, 17'h1ABCD, 8'h5A, lat, we_lo, oe_lo, ga, q);
        check("t1_wr_latency", lat, W + 1);
        check("t1_we_low_clks", we_lo, 1);
        check("t1_wr_addr", int'(ga), 'h1ABCD);
        run_single(0, 1'b0, 17'h1ABCD, 8'h00, lat, we_lo, oe_lo, ga, q);
        check("t1_rd_latency", lat, W + 1);
        check("t1_oe_low_clks", oe_lo, W);
        check("t1_rd_data", int'(q), 'h5A);

        // ---- table-driven single accesses ----
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].d, lat, we_lo, oe_lo, ga, q);
            check("vec_latency", lat, W + 1);
            check("vec_addr", int'(ga), int'(vecs[i].addr));
            if (vecs[i].we) check("vec_we_low", we_lo, W - 1);
            else begin
                check("vec_oe_low", oe_lo, W);
                check("vec_rd_data", int'(q), int'(vecs[i].exp_q));
            end
        end

        // ---- both pending after reset: A first, B after A's recovery ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        a_we = 1'b1; a_addr = 17'h00010; a_d = 8'h11;
        b_we = 1'b1; b_addr = 17'h00020; b_d = 8'h22;
        a_req = ~a_req; b_req = ~b_req;
        k = cyc; t_a = -1; t_b = -1; t_bg = -1; g1addr = '0;
        for (int i = 0; i < 40 && (t_a < 0 || t_b < 0); i++) begin
            tick();
            if (i == 0) g1addr = sram_a;
            if (t_a < 0 && !pending(0)) t_a = cyc;
            if (t_b < 0 && !pending(1)) t_b = cyc;
            if (t_a >= 0 && t_bg < 0 && cyc > t_a && !sram_ce_n) t_bg = cyc;
        end
        check("t2_a_first_latency", t_a - k, W + 1);
        check("t2_first_addr", int'(g1addr), 'h10);
        check("t2_b_grant_after_a_ack", t_bg - t_a, 2);
        check("t2_b_ack_after_a_ack", t_b - t_a, W + 2);
        tick();
        tick();
        run_single(0, 1'b0, 17'h00010, 8'h00, lat, we_lo, oe_lo, ga, q);
        check("t2_rd_a", int'(q), 'h11);
        run_single(1, 1'b0, 17'h00020, 8'h00, lat, we_lo, oe_lo, ga, q);
        check("t2_rd_b", int'(q), 'h22);

        // ---- starvation: A re-requests on every ack, B issues one read ----
        ord.delete();
        a_cnt = 0; b_lat = -1;
        issue(0, 1'b1, 17'h00040, 8'h40);
        a_out = 1'b1;
        tick();
        issue(1, 1'b0, 17'h00020, 8'h00);
        b_out = 1'b1; b_iss = cyc;
        for (int i = 0; i < 80 && ord.size() < 4; i++) begin
            tick();
            if (a_out && !pending(0)) begin
                ord.push_back(0);
                a_out = 1'b0;
                if (a_cnt < 2) begin
                    a_cnt++;
                    issue(0, 1'b1, 17'h00040 + 17'(a_cnt), 8'h40);
                    a_out = 1'b1;
                end
            end
            if (b_out && !pending(1)) begin
                ord.push_back(1);
                b_out = 1'b0;
                b_lat = cyc - b_iss;
            end
        end
        check("t3_ack_count", ord.size(), 4);
        check("t3_order_ABA", (ord.size() >= 3) ? (ord[0] * 4 + ord[1] * 2 + ord[2]) : -1, 2);
        check("t3_b_latency_bound", int'(b_lat > 0 && b_lat <= 2 * W + 4), 1);
        check("t3_b_q", int'(b_q), 'h22);
        tick();
        tick();

        // ---- back-to-back reads on port B ----
        rd_addr[0] = 17'h00020; rd_exp[0] = 8'h22;
        rd_addr[1] = 17'h00010; rd_exp[1] = 8'h11;
        rd_addr[2] = 17'h1ABCD; rd_exp[2] = 8'h5A;
        n = 0; ce_hi = 0; doe_cnt = 0; gap_done = 1'b0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        issue(1, 1'b0, rd_addr[0], 8'h00);
        for (int i = 0; i < 60 && n < 3; i++) begin
            tick();
            if (sram_doe) doe_cnt++;
            if (!pending(1)) begin
                t[n] = cyc;
                check("t4_rd_data", int'(b_q), int'(rd_exp[n]));
                n++;
                if (n < 3) issue(1, 1'b0, rd_addr[n], 8'h00);
            end
            if (n == 1 && !gap_done) begin
                if (sram_ce_n) ce_hi++;
                else gap_done = 1'b1;
            end
        end
        check("t4_ack_count", n, 3);
        check("t4_spacing_1", t[1] - t[0], W + 2);
        check("t4_spacing_2", t[2] - t[1], W + 2);
        check("t4_ce_high_gap", ce_hi, 2);
        check("t4_doe_never", doe_cnt, 0);
        tick();
        tick();

        // ---- reset during a write access ----
        issue(0, 1'b1, 17'h00300, 8'h77);
        tick();
        check("t5_in_access", int'(state_dbg), 1);
        check("t5_we_active", int'(sram_we_n), 0);
        reset = 1'b1;
        tick();
        check("t5_rst_we_n", int'(sram_we_n), 1);
        check("t5_rst_ce_n", int'(sram_ce_n), 1);
        check("t5_rst_doe", int'(sram_doe), 0);
        check("t5_rst_ack_eq_req", int'(a_ack), int'(a_req));
        check("t5_rst_state", int'(state_dbg), 0);
        reset = 1'b0;
        tick();
        run_single(0, 1'b0, 17'h1ABCD, 8'h00, lat, we_lo, oe_lo, ga, q);
        check("t5_fresh_latency", lat, W + 1);
        check("t5_fresh_data", int'(q), 'h5A);

        // ---- wait_cycles=4 instance ----
        run4(1, 1'b0, 17'h00100, 8'h00, lat, oe_lo);
        check("t6_b_latency", lat, W4 + 1);
        check("t6_oe_low_clks", oe_lo, W4);
        check("t6_b_q", int'(b4_q), 'hC3);
        run4(0, 1'b1, 17'h00055, 8'h99, lat, oe_lo);
        check("t6_a_wr_latency", lat, W4 + 1);
        run4(0, 1'b0, 17'h00055, 8'h00, lat, oe_lo);
        check("t6_a_q", int'(a4_q), 'h0F);
        check("t6_b_q_held", int'(b4_q), 'hC3);

        // ---- randomized two-port traffic against a transaction model ----
        pool[0] = 17'h00000; pool[1] = 17'h1FFFF; pool[2] = 17'h00001; pool[3] = 17'h10000;
        pool[4] = 17'h0F0F0; pool[5] = 17'h12345; pool[6] = 17'h1FFFE; pool[7] = 17'h00777;
        for (int i = 0; i < 8; i++) begin
            run_single(i % 2, 1'b1, pool[i], 8'(i * 37 + 3), lat, we_lo, oe_lo, ga, q);
            ref_mem[pool[i]] = 8'(i * 37 + 3);
        end
        out_v[0] = 1'b0; out_v[1] = 1'b0;
        for (int i = 0; i < 900; i++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (out_v[p] && !pending(p)) begin
                    lat = cyc - out_k[p];
                    check("rand_latency_in_bounds", int'(lat >= W + 1 && lat <= 2 * W + 4), 1);
                    if (out_we[p]) ref_mem[out_addr[p]] = out_d[p];
                    else check("rand_rd_data", int'((p == 0) ? a_q : b_q), int'(ref_mem[out_addr[p]]));
                    out_v[p] = 1'b0;
                end
            end
            if (i >= 800 && !out_v[0] && !out_v[1]) break;
            for (int p = 0; p < 2; p++) begin
                if (i < 800 && !out_v[p] && $urandom_range(0, 2) == 0) begin
                    out_we[p]   = 1'($urandom_range(0, 1));
                    out_addr[p] = pool[$urandom_range(0, 7)];
                    out_d[p]    = 8'($urandom);
                    out_k[p]    = cyc;
                    out_v[p]    = 1'b1;
                    issue(p, out_we[p], out_addr[p], out_d[p]);
                end
            end
        end
        check("rand_drained", int'(out_v[0] || out_v[1]), 0);
        check("bus_protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
